// File: rtl/usb_tx_pkg.sv
// Shared packet-type encoding and payload widths for the USB transmit path
// (scheduler, bit-stream encoder and protocol FSM).
package usb_tx_pkg;

  localparam int DATA_W   = 88;
  localparam int TOKEN_W  = 24;
  localparam int HSHAKE_W = 8;

  // The encoder decodes 2'b00 as data, so "nothing to send" must be 2'b11.
  typedef enum logic [1:0] {
    PKT_DATA   = 2'b00,
    PKT_TOKEN  = 2'b01,
    PKT_HSHAKE = 2'b10,
    PKT_NONE   = 2'b11
  } pkt_t;

  // Bit positions of the one-hot grant vector.
  localparam int GNT_DAT = 0;
  localparam int GNT_TOK = 1;
  localparam int GNT_HS  = 2;

  function automatic pkt_t gnt_to_pkt(input logic [2:0] gnt);
    if (gnt[GNT_HS])       return PKT_HSHAKE;
    else if (gnt[GNT_TOK]) return PKT_TOKEN;
    else if (gnt[GNT_DAT]) return PKT_DATA;
    else                   return PKT_NONE;
  endfunction

endpackage

// File: rtl/usb_tx_scheduler_if.sv
// Scheduler-to-encoder bus: packet type, registered payloads and the
// encoder's accept/free status.
// Handshake: a packet is offered while pkt_type != PKT_NONE and is taken on
// the cycle pkt_received is high; free_inbound means the encoder can start
// a new packet.
interface usb_tx_enc_if;
  import usb_tx_pkg::*;

  pkt_t                pkt_type;
  logic [HSHAKE_W-1:0] hshake;
  logic [TOKEN_W-1:0]  token;
  logic [DATA_W-1:0]   data;
  logic                pkt_received;
  logic                free_inbound;

  modport master (
    output pkt_type, hshake, token, data,
    input  pkt_received, free_inbound
  );

  modport slave (
    input  pkt_type, hshake, token, data,
    output pkt_received, free_inbound
  );

endinterface

// File: rtl/usb_tx_scheduler_rr_arbiter.sv
// Combinational requester pick: handshake first, then token/data alternating
// according to which of the two was served last.
module tx_rr_arbiter
  import usb_tx_pkg::*;
(
  input  logic       hs_req,
  input  logic       tok_req,
  input  logic       dat_req,
  input  logic       last,     // 1: data was served last, 0: token was
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    if (hs_req) begin
      gnt[GNT_HS] = 1'b1;
    end else if (tok_req && dat_req) begin
      if (last) gnt[GNT_TOK] = 1'b1;
      else      gnt[GNT_DAT] = 1'b1;
    end else if (tok_req) begin
      gnt[GNT_TOK] = 1'b1;
    end else if (dat_req) begin
      gnt[GNT_DAT] = 1'b1;
    end
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Transmit packet scheduler: arbitrates handshake/token/data requesters onto
// the encoder bus with an inter-packet gap and a stalled-encoder watchdog.
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hs_req,
  input  logic [HSHAKE_W-1:0] hs_pid,
  output logic                hs_ack,
  input  logic                tok_req,
  input  logic [TOKEN_W-1:0]  tok_bits,
  output logic                tok_ack,
  input  logic                dat_req,
  input  logic [DATA_W-1:0]   dat_bits,
  output logic                dat_ack,
  usb_tx_enc_if.master        enc,
  output logic                busy,
  output logic                timeout_err,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic LAST_TOK = 1'b0;
  localparam logic LAST_DAT = 1'b1;

  logic [1:0]          state_q;
  logic                last_q;
  logic [2:0]          gnt_q;
  pkt_t                pkt_type_q;
  logic [HSHAKE_W-1:0] hshake_q;
  logic [TOKEN_W-1:0]  token_q;
  logic [DATA_W-1:0]   data_q;
  logic [GAP_W-1:0]    gap_q;
  logic [WD_W-1:0]     wd_q;
  logic [WD_W-1:0]     wd_inc;
  logic                wd_expire;
  logic [2:0]          gnt;

  tx_rr_arbiter u_arb (
    .hs_req  (hs_req),
    .tok_req (tok_req),
    .dat_req (dat_req),
    .last    (last_q),
    .gnt     (gnt)
  );

  assign wd_inc    = wd_q + WD_W'(1);
  assign wd_expire = (wd_inc == WD_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_DAT;
      gnt_q       <= 3'b000;
      pkt_type_q  <= PKT_NONE;
      hshake_q    <= '0;
      token_q     <= '0;
      data_q      <= '0;
      gap_q       <= '0;
      wd_q        <= '0;
      hs_ack      <= 1'b0;
      tok_ack     <= 1'b0;
      dat_ack     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      hs_ack      <= 1'b0;
      tok_ack     <= 1'b0;
      dat_ack     <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enc.free_inbound && (gnt != 3'b000)) begin
            if (gnt[GNT_HS])  hshake_q <= hs_pid;
            if (gnt[GNT_TOK]) token_q  <= tok_bits;
            if (gnt[GNT_DAT]) data_q   <= dat_bits;
            pkt_type_q <= gnt_to_pkt(gnt);
            gnt_q      <= gnt;
            wd_q       <= '0;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Accept is checked first so it beats a same-cycle watchdog expiry.
          if (enc.pkt_received) begin
            pkt_type_q <= PKT_NONE;
            hs_ack     <= gnt_q[GNT_HS];
            tok_ack    <= gnt_q[GNT_TOK];
            dat_ack    <= gnt_q[GNT_DAT];
            if (gnt_q[GNT_TOK])      last_q <= LAST_TOK;
            else if (gnt_q[GNT_DAT]) last_q <= LAST_DAT;
            wd_q       <= '0;
            state_q    <= ST_BUSY;
          end else if (wd_expire) begin
            timeout_err <= 1'b1;
            pkt_type_q  <= PKT_NONE;
            wd_q        <= '0;
            state_q     <= ST_IDLE;
          end else begin
            wd_q <= wd_inc;
          end
        end
        ST_BUSY: begin
          // wd_q is zero only on the first BUSY cycle, when free_inbound may
          // still reflect the packet that was just handed over.
          if ((wd_q != '0) && enc.free_inbound) begin
            gap_q   <= GAP_W'(GAP_CYCLES);
            wd_q    <= '0;
            state_q <= ST_GAP;
          end else if (wd_expire) begin
            timeout_err <= 1'b1;
            gap_q       <= GAP_W'(GAP_CYCLES);
            wd_q        <= '0;
            state_q     <= ST_GAP;
          end else begin
            wd_q <= wd_inc;
          end
        end
        default: begin
          if (gap_q <= GAP_W'(1)) begin
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
      endcase
    end
  end

  assign enc.pkt_type = pkt_type_q;
  assign enc.hshake   = hshake_q;
  assign enc.token    = token_q;
  assign enc.data     = data_q;
  assign busy         = (state_q != ST_IDLE);
  assign state_dbg    = state_q;

  // The granted requester must keep its request up until it is acknowledged.
  req_held_until_ack: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_ISSUE) |-> ((gnt_q & {hs_req, tok_req, dat_req}) != 3'b000));

endmodule
